rd_empty_sync: RTL and testbench

- Read-domain status stage of the async FIFO.
- Takes the binary read pointer produced by the read-pointer counter. Takes the Gray-coded write pointer from the write clock domain.
- Synchronizes the write pointer into rclk and produces a registered, look-ahead empty flag, almost_empty and fill count. The empty flag is fed back to gate the read-pointer counter.
- Exports the registered Gray read pointer for the write domain's full logic.

---
 rtl/rd_empty_sync.sv | 127 ++++++++++++
 tb/tb_rd_empty_sync.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rd_empty_sync.sv
`default_nettype none
// ============================================================================
// Module      : rd_empty_sync
// Description : Read-domain status stage of the async FIFO. Brings the
//               Gray write pointer into rclk and produces a registered
//               look-ahead empty flag, almost_empty and fill count. It also
//               exports the registered Gray read pointer to the write domain.
//               Optional feature macro: RD_EMPTY_SYNC_UNDERFLOW_EN. When it is
//               defined, the module adds a sticky underflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_empty_sync #(
  parameter int WIDTH       = 8,  // address bits, depth = 2**WIDTH
  parameter int SYNC_STAGES = 2,  // synchronizer depth, 2..4
  parameter int AE_THRESH   = 2   // almost_empty when count <= AE_THRESH
) (
  input  logic             rclk,
  input  logic             rd_rst,
  input  logic             rd_en,
  input  logic [WIDTH:0]   read_ptr,
  input  logic [WIDTH:0]   wr_ptr_gray,
  output logic             empty,
  output logic             almost_empty,
  output logic [WIDTH:0]   rd_count,
  output logic [WIDTH:0]   rd_ptr_gray
`ifdef RD_EMPTY_SYNC_UNDERFLOW_EN
  ,
  output logic             underflow
`endif
);

  localparam int             c_PW        = WIDTH + 1;
  localparam logic [WIDTH:0] c_AE_THRESH = c_PW'(AE_THRESH);
  localparam logic [WIDTH:0] c_ONE       = c_PW'(1);

  // Gray-to-binary conversion: XOR prefix taken from the MSB downward.
  function automatic logic [WIDTH:0] gray_to_bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Write-pointer synchronizer. The stages are plain flops with no logic
  // between them, so a Gray code change that is in flight resolves to either
  // the old value or the new value.
  // --------------------------------------------------------------------------
  logic [WIDTH:0] r_wq_sync [SYNC_STAGES];

  // First stage captures the asynchronous Gray write pointer.
  always_ff @(posedge rclk or posedge rd_rst) begin
    if (rd_rst) begin
      r_wq_sync[0] <= '0;
    end else begin
      r_wq_sync[0] <= wr_ptr_gray;
    end
  end

  genvar s;
  generate
    for (s = 1; s < SYNC_STAGES; s++) begin : g_sync
      // Each further stage re-registers the stage before it.
      always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
          r_wq_sync[s] <= '0;
        end else begin
          r_wq_sync[s] <= r_wq_sync[s-1];
        end
      end
    end
  endgenerate

  logic [WIDTH:0] w_wq_gray;
  logic [WIDTH:0] w_wq_bin;

  assign w_wq_gray = r_wq_sync[SYNC_STAGES-1];
  assign w_wq_bin  = gray_to_bin(w_wq_gray);

  // --------------------------------------------------------------------------
  // Look-ahead read pointer. Each flag is computed from the pointer value
  // that read_ptr takes on this edge. As a result, empty rises on the same
  // edge that consumes the last word.
  // --------------------------------------------------------------------------
  logic           w_rd_inc;
  logic [WIDTH:0] w_rptr_next;
  logic [WIDTH:0] w_rgray_next;
  logic [WIDTH:0] w_count_next;

  // Next-pointer, Gray form and fill count. All math is modulo 2**(WIDTH+1).
  always_comb begin
    w_rd_inc     = rd_en & ~empty;
    w_rptr_next  = read_ptr + (w_rd_inc ? c_ONE : '0);
    w_rgray_next = w_rptr_next ^ (w_rptr_next >> 1);
    w_count_next = w_wq_bin - w_rptr_next;
  end

  // Registered status. The reset state reports an empty FIFO.
  always_ff @(posedge rclk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
    end else begin
      rd_ptr_gray  <= w_rgray_next;
      empty        <= (w_rgray_next == w_wq_gray);
      almost_empty <= (w_count_next <= c_AE_THRESH);
      rd_count     <= w_count_next;
    end
  end

`ifdef RD_EMPTY_SYNC_UNDERFLOW_EN
  // Sticky underflow flag. Only rd_rst clears it.
  always_ff @(posedge rclk or posedge rd_rst) begin
    if (rd_rst) begin
      underflow <= 1'b0;
    end else if (rd_en && empty) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_empty_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_empty_sync
// Description : Directed self-checking bench for rd_empty_sync with
//               WIDTH=3, SYNC_STAGES=2, AE_THRESH=2. It includes a model of
//               the read-pointer counter that the empty flag gates.
//               The optional RD_EMPTY_SYNC_UNDERFLOW_EN checks are compiled
//               in when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_empty_sync;

  localparam int WIDTH = 3;

  logic             rclk = 1'b0;
  logic             rd_rst = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH:0]   read_ptr;
  logic [WIDTH:0]   wr_ptr_gray = '0;
  logic             empty;
  logic             almost_empty;
  logic [WIDTH:0]   rd_count;
  logic [WIDTH:0]   rd_ptr_gray;
`ifdef RD_EMPTY_SYNC_UNDERFLOW_EN
  logic             underflow;
`endif

  logic             ld_en = 1'b0;
  logic [WIDTH:0]   ld_val = '0;

  int total = 0;
  int bad   = 0;

  rd_empty_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .AE_THRESH   (2)
  ) dut (
    .rclk         (rclk),
    .rd_rst       (rd_rst),
    .rd_en        (rd_en),
    .read_ptr     (read_ptr),
    .wr_ptr_gray  (wr_ptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .rd_ptr_gray  (rd_ptr_gray)
`ifdef RD_EMPTY_SYNC_UNDERFLOW_EN
    ,
    .underflow    (underflow)
`endif
  );

  always #5 rclk = ~rclk;

  // Read-pointer counter gated by empty. The bench can load it directly.
  always @(posedge rclk or posedge rd_rst) begin
    if (rd_rst)               read_ptr <= '0;
    else if (ld_en)           read_ptr <= ld_val;
    else if (rd_en && !empty) read_ptr <= read_ptr + 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  initial begin
    // Power-up reset, released between edges (edges fall at 5, 15, 25, ...).
    wr_ptr_gray = 4'd5;
    #2 rd_rst = 1'b1;
    #1;
    check("por_empty", empty, 1);
    check("por_count", rd_count, 0);
    #9 rd_rst = 1'b0;                      // t=12

    // Gray 5 -> binary 6. The value is visible after 3 edges.
    edges(3);                              // t=36
    check("g5_count", rd_count, 6);
    check("g5_empty", empty, 0);
    check("g5_ae", almost_empty, 0);

    // Mid-cycle asynchronous reset. Outputs clear without an edge.
    #3 rd_rst = 1'b1;                      // t=39
    #1;
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_count", rd_count, 0);
    check("rst_rgray", rd_ptr_gray, 0);
    wr_ptr_gray = '0;
    #3 rd_rst = 1'b0;                      // t=43

    // Fill latency: one write becomes visible on the 3rd edge.
    edges(3);
    check("idle_empty", empty, 1);
    wr_ptr_gray = 4'd1;
    edges(2);
    check("lat2_empty", empty, 1);
    edges(1);
    check("lat3_empty", empty, 0);
    check("lat3_count", rd_count, 1);
    check("lat3_ae", almost_empty, 1);

    // Drain. wq = 3 (Gray 2). With rd_en held, the count goes 2, 1, 0.
    wr_ptr_gray = 4'd2;
    edges(3);
    check("w3_count", rd_count, 3);
    check("w3_ae", almost_empty, 0);
    rd_en = 1'b1;
    edges(1);
    check("d1_ptr", read_ptr, 1);
    check("d1_count", rd_count, 2);
    check("d1_ae", almost_empty, 1);
    edges(1);
    check("d2_count", rd_count, 1);
    check("d2_empty", empty, 0);
    edges(1);
    check("d3_ptr", read_ptr, 3);
    check("d3_count", rd_count, 0);
    check("d3_empty", empty, 1);
    rd_en = 1'b0;

    // rd_en while empty is ignored. Without the macro, nothing moves.
`ifndef RD_EMPTY_SYNC_UNDERFLOW_EN
    rd_en = 1'b1;
    edges(1);
    check("ign_ptr", read_ptr, 3);
    check("ign_empty", empty, 1);
    check("ign_rgray", rd_ptr_gray, 2);
    rd_en = 1'b0;
`endif

    // Wrap: read_ptr = 15 and wq = 1. The count is 2.
    ld_en = 1'b1; ld_val = 4'd15; wr_ptr_gray = 4'd1;
    edges(1);
    ld_en = 1'b0;
    edges(2);
    check("wrap_count", rd_count, 2);
    check("wrap_empty", empty, 0);
    check("wrap_ae", almost_empty, 1);
    rd_en = 1'b1;
    edges(1);
    check("wrap_r1_ptr", read_ptr, 0);
    check("wrap_r1_count", rd_count, 1);
    edges(1);
    rd_en = 1'b0;
    check("wrap_r2_ptr", read_ptr, 1);
    check("wrap_r2_rgray", rd_ptr_gray, 1);
    check("wrap_r2_empty", empty, 1);

    // Full: wq = 8 (Gray 12) and read_ptr = 0.
    ld_en = 1'b1; ld_val = 4'd0; wr_ptr_gray = 4'd12;
    edges(1);
    ld_en = 1'b0;
    edges(2);
    check("full_count", rd_count, 8);
    check("full_empty", empty, 0);
    check("full_ae", almost_empty, 0);

`ifdef RD_EMPTY_SYNC_UNDERFLOW_EN
    // Return to empty (wq = 0), then read while empty.
    wr_ptr_gray = 4'd0;
    edges(3);
    check("uf_pre_empty", empty, 1);
    check("uf_pre", underflow, 0);
    rd_en = 1'b1;
    edges(1);
    rd_en = 1'b0;
    check("uf_set", underflow, 1);
    check("uf_ptr", read_ptr, 0);
    // A valid read afterwards does not clear the flag.
    wr_ptr_gray = 4'd3;                    // Gray 3 -> binary 2
    edges(3);
    rd_en = 1'b1;
    edges(1);
    rd_en = 1'b0;
    check("uf_hold_ptr", read_ptr, 1);
    check("uf_hold", underflow, 1);
    #2 rd_rst = 1'b1;
    #1;
    check("uf_clr", underflow, 0);
    #2 rd_rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
